sd_dma_job_sched: RTL and testbench

SD_DMA_JOB_SCHED -- requirements
Module: sd_dma_job_sched

---
 rtl/sd_dma_job_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_sd_dma_job_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dma_job_sched.sv
// sd_dma_job_sched: register-based job queue that feeds an SD-card read DMA
// one job at a time. A small FSM (IDLE/RUN/GAP) launches the head job, holds
// the DMA parameters steady while it runs, and signals completion with an
// irq pulse and a completed-job counter.
// Optional feature macro: SD_DMA_TIMEOUT_EN adds a per-job RUN watchdog that
// aborts a job after TIMEOUT_CYCLES cycles and raises a sticky err_timeout.
module sd_dma_job_sched #(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         job_push,
  input  logic [31:0]                  job_sec_start,
  input  logic [31:0]                  job_sec_num,
  input  logic [ADDR_WIDTH-1:0]        job_ddr_base,
  input  logic                         sd_init_done,
  input  logic                         dma_done,
  input  logic                         clear_err,
  output logic                         job_full,
  output logic [$clog2(QUEUE_DEPTH):0] job_count,
  output logic                         dma_start,
  output logic [31:0]                  dma_sec_start,
  output logic [31:0]                  dma_sec_num,
  output logic [ADDR_WIDTH-1:0]        dma_ddr_base,
  output logic                         irq,
  output logic [15:0]                  jobs_done,
  output logic                         err_overflow,
  output logic                         err_timeout
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_DEPTH);

  // Reject configurations the pointer arithmetic cannot support.
  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES == 32'd0) begin : g_param_check
    $error("sd_dma_job_sched: QUEUE_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES non-zero");
  end

  typedef struct packed {
    logic [31:0]           secStart;
    logic [31:0]           secNum;
    logic [ADDR_WIDTH-1:0] ddrBase;
  } jobEntry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state_q;
  jobEntry_t             queue_q [QUEUE_DEPTH];
  jobEntry_t             headEntry;
  logic [PW-1:0]         wrPtr_q, wrPtr_d;
  logic [PW-1:0]         rdPtr_q, rdPtr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  fullNow;
  logic                  pushOk;
  logic                  pushDrop;
  logic                  popNow;

  logic                  dmaStart_q;
  logic [31:0]           dmaSecStart_q;
  logic [31:0]           dmaSecNum_q;
  logic [ADDR_WIDTH-1:0] dmaDdrBase_q;
  logic                  irq_q;
  logic [15:0]           jobsDone_q;
  logic                  errOverflow_q;

`ifdef SD_DMA_TIMEOUT_EN
  logic                  errTimeout_q;
  logic [31:0]           tmoCnt_q;
`endif

  assign fullNow   = (count_q == CNT_FULL);
  assign pushOk    = job_push && !fullNow;
  assign pushDrop  = job_push && fullNow;
  assign popNow    = (state_q == IDLE) && (count_q != '0) && sd_init_done;
  assign headEntry = queue_q[rdPtr_q];

  // Next pointer and occupancy values; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (popNow) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    case ({pushOk, popNow})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Job storage; contents only matter once counted, so no reset is needed.
  always_ff @(posedge sys_clk) begin
    if (pushOk) begin
      queue_q[wrPtr_q] <= '{secStart: job_sec_start,
                            secNum:   job_sec_num,
                            ddrBase:  job_ddr_base};
    end
  end

  // Queue pointers and occupancy; reset empties the queue immediately.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Job sequencing FSM with its registered DMA interface, irq, counters and sticky errors.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dmaStart_q    <= 1'b0;
      dmaSecStart_q <= '0;
      dmaSecNum_q   <= '0;
      dmaDdrBase_q  <= '0;
      irq_q         <= 1'b0;
      jobsDone_q    <= '0;
      errOverflow_q <= 1'b0;
`ifdef SD_DMA_TIMEOUT_EN
      errTimeout_q  <= 1'b0;
      tmoCnt_q      <= '0;
`endif
    end else begin
      irq_q <= 1'b0;

      if (pushDrop) begin
        errOverflow_q <= 1'b1;
      end else if (clear_err) begin
        errOverflow_q <= 1'b0;
      end

`ifdef SD_DMA_TIMEOUT_EN
      if (clear_err) begin
        errTimeout_q <= 1'b0;
      end
`endif

      case (state_q)
        IDLE: begin
          if (popNow) begin
            dmaSecStart_q <= headEntry.secStart;
            dmaSecNum_q   <= headEntry.secNum;
            dmaDdrBase_q  <= headEntry.ddrBase;
            if (headEntry.secNum != 32'd0) begin
              dmaStart_q <= 1'b1;
              state_q    <= RUN;
`ifdef SD_DMA_TIMEOUT_EN
              tmoCnt_q   <= '0;
`endif
            end else begin
              irq_q      <= 1'b1;
              jobsDone_q <= jobsDone_q + 16'd1;
              state_q    <= GAP;
            end
          end
        end

        RUN: begin
          if (dma_done) begin
            dmaStart_q <= 1'b0;
            irq_q      <= 1'b1;
            jobsDone_q <= jobsDone_q + 16'd1;
            state_q    <= GAP;
          end
`ifdef SD_DMA_TIMEOUT_EN
          else if (tmoCnt_q == TIMEOUT_CYCLES - 32'd1) begin
            dmaStart_q   <= 1'b0;
            errTimeout_q <= 1'b1;
            irq_q        <= 1'b1;
            state_q      <= GAP;
          end else begin
            tmoCnt_q <= tmoCnt_q + 32'd1;
          end
`endif
        end

        GAP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q    <= IDLE;
          dmaStart_q <= 1'b0;
        end
      endcase
    end
  end

  assign job_full      = fullNow;
  assign job_count     = count_q;
  assign dma_start     = dmaStart_q;
  assign dma_sec_start = dmaSecStart_q;
  assign dma_sec_num   = dmaSecNum_q;
  assign dma_ddr_base  = dmaDdrBase_q;
  assign irq           = irq_q;
  assign jobs_done     = jobsDone_q;
  assign err_overflow  = errOverflow_q;

`ifdef SD_DMA_TIMEOUT_EN
  assign err_timeout   = errTimeout_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sd_dma_job_sched.sv
// tb_sd_dma_job_sched: scoreboard bench for sd_dma_job_sched. Accepted jobs
// are queued as expectations when pushed; a monitor compares the DMA
// parameters on every dma_start rising edge and retires one expectation per
// irq pulse. Define SD_DMA_TIMEOUT_EN to also exercise the RUN watchdog.
module tb_sd_dma_job_sched;

  localparam int QD = 4;
  localparam int AW = 32;

  logic                 sys_clk = 1'b0;
  logic                 rst_n;
  logic                 job_push;
  logic [31:0]          job_sec_start;
  logic [31:0]          job_sec_num;
  logic [AW-1:0]        job_ddr_base;
  logic                 sd_init_done;
  logic                 dma_done;
  logic                 clear_err;
  logic                 job_full;
  logic [$clog2(QD):0]  job_count;
  logic                 dma_start;
  logic [31:0]          dma_sec_start;
  logic [31:0]          dma_sec_num;
  logic [AW-1:0]        dma_ddr_base;
  logic                 irq;
  logic [15:0]          jobs_done;
  logic                 err_overflow;
  logic                 err_timeout;

  typedef struct packed {
    logic [31:0]   secStart;
    logic [31:0]   secNum;
    logic [AW-1:0] base;
    logic          timeout;
  } expJob_t;

  expJob_t sbQ[$];
  int      checks  = 0;
  int      errors  = 0;
  int      tbDone  = 0;
  int      irqSeen = 0;
  logic    prevStart = 1'b0;

  sd_dma_job_sched #(
    .QUEUE_DEPTH    (QD),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .job_push      (job_push),
    .job_sec_start (job_sec_start),
    .job_sec_num   (job_sec_num),
    .job_ddr_base  (job_ddr_base),
    .sd_init_done  (sd_init_done),
    .dma_done      (dma_done),
    .clear_err     (clear_err),
    .job_full      (job_full),
    .job_count     (job_count),
    .dma_start     (dma_start),
    .dma_sec_start (dma_sec_start),
    .dma_sec_num   (dma_sec_num),
    .dma_ddr_base  (dma_ddr_base),
    .irq           (irq),
    .jobs_done     (jobs_done),
    .err_overflow  (err_overflow),
    .err_timeout   (err_timeout)
  );

  // 100 MHz clock
  always #5 sys_clk = ~sys_clk;

  // Counts one comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one push cycle and records the job as expected work if the queue should accept it
  task automatic applyStimulus(input logic [31:0] sec, input logic [31:0] num,
                               input logic [AW-1:0] base, input bit accepted, input bit tmo);
    expJob_t e;
    @(negedge sys_clk);
    job_push      = 1'b1;
    job_sec_start = sec;
    job_sec_num   = num;
    job_ddr_base  = base;
    if (accepted) begin
      e.secStart = sec;
      e.secNum   = num;
      e.base     = base;
      e.timeout  = tmo;
      sbQ.push_back(e);
    end
    @(negedge sys_clk);
    job_push = 1'b0;
  endtask

  // Waits (bounded) for dma_start to be high on a falling edge
  task automatic waitStart(input string tag);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 50) begin
      if (n != 0 || !dma_start) @(negedge sys_clk);
      seen = dma_start;
      n++;
    end
    checkOutput(tag, 64'(seen), 64'd1);
  endtask

  // Lets the running job run briefly, then completes it with a dma_done pulse
  task automatic finishJob();
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 50) begin
      @(negedge sys_clk);
      seen = dma_start;
      n++;
    end
    checkOutput("finishStartSeen", 64'(seen), 64'd1);
    if (seen) begin
      repeat (2) @(negedge sys_clk);
      checkOutput("startHeld", 64'(dma_start), 64'd1);
      dma_done = 1'b1;
      @(negedge sys_clk);
      dma_done = 1'b0;
      checkOutput("irqAfterDone", 64'(irq), 64'd1);
      checkOutput("startLowAfterDone", 64'(dma_start), 64'd0);
      @(negedge sys_clk);
      checkOutput("irqOneCycle", 64'(irq), 64'd0);
      checkOutput("startLowInGap", 64'(dma_start), 64'd0);
    end
  endtask

  // Scoreboard monitor: checks launch parameters and retires one job per irq
  always @(posedge sys_clk) begin
    expJob_t e;
    #1;
    if (rst_n) begin
      if (dma_start && !prevStart) begin
        checkOutput("sbJobAtStart", 64'(sbQ.size() != 0), 64'd1);
        if (sbQ.size() != 0) begin
          e = sbQ[0];
          checkOutput("startSecStart", 64'(dma_sec_start), 64'(e.secStart));
          checkOutput("startSecNum", 64'(dma_sec_num), 64'(e.secNum));
          checkOutput("startDdrBase", 64'(dma_ddr_base), 64'(e.base));
        end
      end
      if (irq) begin
        irqSeen++;
        checkOutput("sbJobAtIrq", 64'(sbQ.size() != 0), 64'd1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          if (!e.timeout) tbDone++;
          checkOutput("irqSecStart", 64'(dma_sec_start), 64'(e.secStart));
          checkOutput("irqSecNum", 64'(dma_sec_num), 64'(e.secNum));
          checkOutput("irqDdrBase", 64'(dma_ddr_base), 64'(e.base));
          checkOutput("irqJobsDone", 64'(jobs_done), 64'(16'(tbDone)));
          checkOutput("irqTimeoutFlag", 64'(err_timeout), 64'(e.timeout));
        end
      end
    end
    prevStart = dma_start;
  end

  // Hard stop in case the sequence stalls
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence
  initial begin
    bit sawStart;
    int irqBefore;
    int cnt;

    rst_n         = 1'b1;
    job_push      = 1'b0;
    job_sec_start = '0;
    job_sec_num   = '0;
    job_ddr_base  = '0;
    sd_init_done  = 1'b1;
    dma_done      = 1'b0;
    clear_err     = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);

    checkOutput("rstDmaStart", 64'(dma_start), 64'd0);
    checkOutput("rstJobCount", 64'(job_count), 64'd0);
    checkOutput("rstJobFull", 64'(job_full), 64'd0);
    checkOutput("rstJobsDone", 64'(jobs_done), 64'd0);
    checkOutput("rstIrq", 64'(irq), 64'd0);
    checkOutput("rstErrOvf", 64'(err_overflow), 64'd0);
    checkOutput("rstErrTmo", 64'(err_timeout), 64'd0);
    checkOutput("rstSecStart", 64'(dma_sec_start), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single job with launch latency and completion handshake
    $display("[TB] single job");
    applyStimulus(32'd100, 32'd8, 32'h8000_0000, 1'b1, 1'b0);
    checkOutput("t1StartNotYet", 64'(dma_start), 64'd0);
    checkOutput("t1CountOne", 64'(job_count), 64'd1);
    @(negedge sys_clk);
    checkOutput("t1StartHigh", 64'(dma_start), 64'd1);
    checkOutput("t1CountZero", 64'(job_count), 64'd0);
    checkOutput("t1SecStart", 64'(dma_sec_start), 64'd100);
    checkOutput("t1SecNum", 64'(dma_sec_num), 64'd8);
    checkOutput("t1Base", 64'(dma_ddr_base), 64'h8000_0000);
    finishJob();
    checkOutput("t1JobsDone", 64'(jobs_done), 64'd1);

    // Overflow while one job runs; order of execution follows push order
    $display("[TB] queue overflow");
    applyStimulus(32'd10, 32'd4, 32'h0000_1000, 1'b1, 1'b0);
    waitStart("t2FirstLaunch");
    applyStimulus(32'd20, 32'd1, 32'h0000_2000, 1'b1, 1'b0);
    applyStimulus(32'd30, 32'd2, 32'h0000_3000, 1'b1, 1'b0);
    applyStimulus(32'd40, 32'd3, 32'h0000_4000, 1'b1, 1'b0);
    applyStimulus(32'd50, 32'd4, 32'h0000_5000, 1'b1, 1'b0);
    checkOutput("t2FullBeforeDrop", 64'(job_full), 64'd1);
    applyStimulus(32'd60, 32'd5, 32'h0000_6000, 1'b0, 1'b0);
    checkOutput("t2Count", 64'(job_count), 64'd4);
    checkOutput("t2Full", 64'(job_full), 64'd1);
    checkOutput("t2Overflow", 64'(err_overflow), 64'd1);
    @(negedge sys_clk);
    clear_err = 1'b1;
    @(negedge sys_clk);
    clear_err = 1'b0;
    checkOutput("t2OverflowCleared", 64'(err_overflow), 64'd0);
    for (int i = 0; i < 5; i++) finishJob();
    checkOutput("t2CountDrained", 64'(job_count), 64'd0);
    checkOutput("t2FullDrained", 64'(job_full), 64'd0);
    checkOutput("t2JobsDone", 64'(jobs_done), 64'd6);

    // dma_done outside RUN has no effect
    @(negedge sys_clk);
    dma_done = 1'b1;
    @(negedge sys_clk);
    dma_done = 1'b0;
    checkOutput("strayDoneIrq", 64'(irq), 64'd0);
    checkOutput("strayDoneJobs", 64'(jobs_done), 64'd6);

    // Zero-length job completes without a DMA launch
    $display("[TB] zero-length job");
    irqBefore = irqSeen;
    sawStart  = 1'b0;
    applyStimulus(32'd200, 32'd0, 32'h0000_7000, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      sawStart |= dma_start;
    end
    checkOutput("t3NoStart", 64'(sawStart), 64'd0);
    checkOutput("t3IrqCount", 64'(irqSeen - irqBefore), 64'd1);
    checkOutput("t3JobsDone", 64'(jobs_done), 64'd7);

    // Launches stall until the card reports initialised
    $display("[TB] init gating");
    sd_init_done = 1'b0;
    applyStimulus(32'd300, 32'd2, 32'h0000_3300, 1'b1, 1'b0);
    applyStimulus(32'd400, 32'd3, 32'h0000_4400, 1'b1, 1'b0);
    sawStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      sawStart |= dma_start;
    end
    checkOutput("t4NoStart", 64'(sawStart), 64'd0);
    checkOutput("t4CountHeld", 64'(job_count), 64'd2);
    sd_init_done = 1'b1;
    @(negedge sys_clk);
    checkOutput("t4LaunchAfterInit", 64'(dma_start), 64'd1);
    checkOutput("t4CountAfterPop", 64'(job_count), 64'd1);
    finishJob();
    finishJob();
    checkOutput("t4JobsDone", 64'(jobs_done), 64'd9);

    // Asynchronous reset in the middle of a running job
    $display("[TB] reset during run");
    applyStimulus(32'd600, 32'd5, 32'h0000_6600, 1'b1, 1'b0);
    waitStart("t5Launch");
    applyStimulus(32'd700, 32'd6, 32'h0000_7700, 1'b1, 1'b0);
    applyStimulus(32'd800, 32'd7, 32'h0000_8800, 1'b1, 1'b0);
    checkOutput("t5Queued", 64'(job_count), 64'd2);
    @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5StartDropped", 64'(dma_start), 64'd0);
    checkOutput("t5CountCleared", 64'(job_count), 64'd0);
    checkOutput("t5JobsDoneCleared", 64'(jobs_done), 64'd0);
    checkOutput("t5SecStartCleared", 64'(dma_sec_start), 64'd0);
    sbQ.delete();
    tbDone = 0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    sawStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      sawStart |= dma_start;
    end
    checkOutput("t5QueueLost", 64'(sawStart), 64'd0);
    checkOutput("t5CountAfter", 64'(job_count), 64'd0);

`ifdef SD_DMA_TIMEOUT_EN
    // RUN watchdog aborts a job that never completes
    $display("[TB] timeout");
    applyStimulus(32'd500, 32'd1, 32'h0000_5500, 1'b1, 1'b1);
    waitStart("t6Launch");
    cnt = 0;
    while (dma_start && cnt < 200) begin
      cnt++;
      @(negedge sys_clk);
    end
    checkOutput("t6RunCycles", 64'(cnt), 64'd100);
    checkOutput("t6ErrTimeout", 64'(err_timeout), 64'd1);
    checkOutput("t6Irq", 64'(irq), 64'd1);
    checkOutput("t6JobsDone", 64'(jobs_done), 64'd0);
    @(negedge sys_clk);
    clear_err = 1'b1;
    @(negedge sys_clk);
    clear_err = 1'b0;
    checkOutput("t6TimeoutCleared", 64'(err_timeout), 64'd0);
`else
    cnt = 0;
`endif

    repeat (3) @(negedge sys_clk);
    checkOutput("sbDrained", 64'(sbQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
